// File: rtl/red_pitaya_dac_slew_if.sv
// Control/data bundle between the ASG channel generator side and the DAC slew limiter.
// The master side drives the target code and controls; the slave (limiter) returns the conditioned code and status.
interface red_pitaya_dac_slew_if #(
    parameter int DW = 14,
    parameter int CW = 16
);
    logic [DW-1:0] dat_i;
    logic [DW-1:0] set_step_i;
    logic          set_bypass_i;
    logic          set_hold_i;
    logic          zero_req_i;
    logic          clr_cnt_i;
    logic [DW-1:0] dat_o;
    logic          limiting_o;
    logic          parked_o;
    logic [CW-1:0] lim_cnt_o;

    modport master (
        output dat_i, set_step_i, set_bypass_i, set_hold_i, zero_req_i, clr_cnt_i,
        input  dat_o, limiting_o, parked_o, lim_cnt_o
    );

    modport slave (
        input  dat_i, set_step_i, set_bypass_i, set_hold_i, zero_req_i, clr_cnt_i,
        output dat_o, limiting_o, parked_o, lim_cnt_o
    );
endinterface

// File: rtl/red_pitaya_dac_slew.sv
// Per-channel DAC slew limiter: bounds the per-cycle change of the DAC code, with hold,
// bypass, ramp-to-zero park and a saturating count of clipped cycles.
module red_pitaya_dac_slew #(
    parameter int DW = 14,
    parameter int CW = 16
) (
    input logic               dac_clk_i,
    input logic               dac_rstn_i,
    red_pitaya_dac_slew_if.slave bus
);

    typedef enum logic [2:0] {
        ST_TRACK,
        ST_BYPASS,
        ST_HOLD,
        ST_RAMP_ZERO,
        ST_PARKED
    } state_t;

    localparam logic [DW:0]   ONE_X = {{DW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [DW-1:0] y_q, y_d;
    logic          limiting_q, limiting_d;
    logic [CW-1:0] lim_cnt_q, lim_cnt_d;

    logic [DW-1:0] tgt;
    logic [DW:0]   tgt_ext, y_ext, diff, diff_abs, step_ext;
    logic          slew_clip;
    logic [DW-1:0] slew_y;

    // Difference and magnitude are taken one bit wider so full-scale swings cannot overflow.
    assign tgt      = bus.zero_req_i ? '0 : bus.dat_i;
    assign tgt_ext  = {tgt[DW-1], tgt};
    assign y_ext    = {y_q[DW-1], y_q};
    assign diff     = tgt_ext - y_ext;
    assign diff_abs = diff[DW] ? (~diff + ONE_X) : diff;
    assign step_ext = {1'b0, bus.set_step_i};

    assign slew_clip = (bus.set_step_i != '0) && (diff_abs > step_ext);
    // A clipped result lies strictly between y and the target, so DW-bit arithmetic cannot wrap.
    assign slew_y    = !slew_clip ? tgt
                     : (diff[DW] ? (y_q - bus.set_step_i) : (y_q + bus.set_step_i));

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        limiting_d = 1'b0;
        if (state_q == ST_PARKED) begin
            if (bus.zero_req_i) begin
                state_d = ST_PARKED;
                y_d     = '0;
            end else begin
                state_d    = ST_TRACK;
                y_d        = slew_y;
                limiting_d = slew_clip;
            end
        end else if (bus.zero_req_i) begin
            state_d    = (slew_y == '0) ? ST_PARKED : ST_RAMP_ZERO;
            y_d        = slew_y;
            limiting_d = slew_clip;
        end else if (bus.set_hold_i) begin
            state_d = ST_HOLD;
        end else if (bus.set_bypass_i) begin
            state_d = ST_BYPASS;
            y_d     = bus.dat_i;
        end else begin
            state_d    = ST_TRACK;
            y_d        = slew_y;
            limiting_d = slew_clip;
        end
    end

    // Clear beats increment; the counter sticks at all-ones.
    always_comb begin
        lim_cnt_d = lim_cnt_q;
        if (bus.clr_cnt_i) begin
            lim_cnt_d = '0;
        end else if (limiting_d && (lim_cnt_q != '1)) begin
            lim_cnt_d = lim_cnt_q + ONE_C;
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state_q <= ST_TRACK;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            y_q        <= '0;
            limiting_q <= 1'b0;
            lim_cnt_q  <= '0;
        end else begin
            y_q        <= y_d;
            limiting_q <= limiting_d;
            lim_cnt_q  <= lim_cnt_d;
        end
    end

    assign bus.dat_o      = y_q;
    assign bus.limiting_o = limiting_q;
    assign bus.parked_o   = (state_q == ST_PARKED);
    assign bus.lim_cnt_o  = lim_cnt_q;

endmodule

// File: tb/tb_red_pitaya_dac_slew.sv
// Directed bench for the DAC slew limiter: a behavioural model pushes expected outputs
// into a scoreboard queue as each step is driven; they are popped and checked after the edge.
`timescale 1ns/1ps
module tb_red_pitaya_dac_slew;

    localparam int M_TRACK = 0, M_BYPASS = 1, M_HOLD = 2, M_RAMP = 3, M_PARKED = 4;

    typedef struct {
        string tag;
        int    y;
        bit    lim;
        bit    park;
        int    cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   m_y, m_st, m_cnt;
    exp_t sb[$];

    red_pitaya_dac_slew_if #(.DW(14), .CW(16)) bus ();

    red_pitaya_dac_slew #(.DW(14), .CW(16)) dut (
        .dac_clk_i (clk),
        .dac_rstn_i(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_y = 0; m_st = M_TRACK; m_cnt = 0;
    endtask

    // Behavioural reference written directly from the update rules in integer arithmetic.
    task automatic model_step(input string tag);
        int  dat, stp, t, d, ad;
        bit  slew, lim;
        exp_t e;
        dat  = int'($signed(bus.dat_i));
        stp  = int'(bus.set_step_i);
        slew = 1'b0;
        lim  = 1'b0;
        t    = dat;
        if (m_st == M_PARKED && bus.zero_req_i) begin
            m_y = 0;
        end else if (m_st == M_PARKED) begin
            m_st = M_TRACK; slew = 1'b1;
        end else if (bus.zero_req_i) begin
            m_st = M_RAMP; t = 0; slew = 1'b1;
        end else if (bus.set_hold_i) begin
            m_st = M_HOLD;
        end else if (bus.set_bypass_i) begin
            m_st = M_BYPASS; m_y = dat;
        end else begin
            m_st = M_TRACK; slew = 1'b1;
        end
        if (slew) begin
            d  = t - m_y;
            ad = (d < 0) ? -d : d;
            if (stp == 0 || ad <= stp) begin
                m_y = t;
            end else begin
                m_y = (d > 0) ? m_y + stp : m_y - stp;
                lim = 1'b1;
            end
            if (m_st == M_RAMP && m_y == 0) m_st = M_PARKED;
        end
        if (bus.clr_cnt_i) m_cnt = 0;
        else if (lim && m_cnt < 65535) m_cnt = m_cnt + 1;
        e.tag = tag; e.y = m_y; e.lim = lim; e.park = (m_st == M_PARKED); e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic step(input string tag, input bit verbose);
        exp_t e;
        model_step(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_int({e.tag, ".dat_o"},      int'($signed(bus.dat_o)), e.y);
        check_int({e.tag, ".limiting_o"}, int'(bus.limiting_o),     int'(e.lim));
        check_int({e.tag, ".parked_o"},   int'(bus.parked_o),       int'(e.park));
        check_int({e.tag, ".lim_cnt_o"},  int'(bus.lim_cnt_o),      e.cnt);
        if (verbose)
            $display("step %-12s dat_i=%0d step=%0d zr=%b hold=%b byp=%b clr=%b -> dat_o=%0d lim=%b park=%b cnt=%0d",
                     tag, $signed(bus.dat_i), bus.set_step_i, bus.zero_req_i, bus.set_hold_i,
                     bus.set_bypass_i, bus.clr_cnt_i, $signed(bus.dat_o), bus.limiting_o,
                     bus.parked_o, bus.lim_cnt_o);
    endtask

    task automatic drive(input int dat, input int stp);
        bus.dat_i      = 14'(dat);
        bus.set_step_i = 14'(stp);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.dat_i = '0; bus.set_step_i = '0; bus.set_bypass_i = 1'b0;
        bus.set_hold_i = 1'b0; bus.zero_req_i = 1'b0; bus.clr_cnt_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_int("reset.dat_o",      int'(bus.dat_o),      0);
        check_int("reset.limiting_o", int'(bus.limiting_o), 0);
        check_int("reset.parked_o",   int'(bus.parked_o),   0);
        check_int("reset.lim_cnt_o",  int'(bus.lim_cnt_o),  0);
        rst_n = 1'b1;

        // Ramp 0 -> 1000 in steps of 100
        drive(1000, 100);
        for (int i = 1; i <= 10; i++) step($sformatf("track%0d", i), 1'b1);
        check_int("track.final_dat",  int'($signed(bus.dat_o)), 1000);
        check_int("track.final_lim",  int'(bus.limiting_o),     0);
        check_int("track.final_cnt",  int'(bus.lim_cnt_o),      9);

        // Full-scale swing +8191 -> -8192
        drive(8191, 0);      step("fs_settle", 1'b1);
        drive(-8192, 4096);
        for (int i = 1; i <= 4; i++) step($sformatf("fs%0d", i), 1'b1);
        check_int("fs.final_dat", int'($signed(bus.dat_o)), -8192);
        check_int("fs.final_lim", int'(bus.limiting_o),     0);
        drive(8191, 0);      step("fs0_up", 1'b1);
        drive(-8192, 0);     step("fs0_down", 1'b1);
        check_int("fs0.dat", int'($signed(bus.dat_o)), -8192);

        // Ramp to zero and park
        drive(-500, 0);      step("rz_set", 1'b1);
        drive(-500, 64);     bus.zero_req_i = 1'b1;
        for (int i = 1; i <= 8; i++) step($sformatf("rz%0d", i), 1'b1);
        check_int("rz.park", int'(bus.parked_o),        1);
        check_int("rz.dat",  int'($signed(bus.dat_o)), 0);
        drive(3000, 64);
        step("parked1", 1'b1);
        step("parked2", 1'b1);
        bus.zero_req_i = 1'b0;
        step("unpark1", 1'b1);
        step("unpark2", 1'b1);
        check_int("unpark.dat", int'($signed(bus.dat_o)), 128);

        // Hold mid-ramp at 300
        drive(200, 0);       step("hold_set", 1'b1);
        drive(1000, 100);    step("hold_pre", 1'b1);
        bus.set_hold_i = 1'b1;
        for (int i = 1; i <= 5; i++) step($sformatf("hold%0d", i), 1'b1);
        check_int("hold.dat", int'($signed(bus.dat_o)), 300);
        bus.set_hold_i = 1'b0;
        step("hold_rel", 1'b1);
        check_int("hold_rel.dat", int'($signed(bus.dat_o)), 400);
        bus.set_hold_i = 1'b1; bus.zero_req_i = 1'b1;
        step("hold_zr", 1'b1);
        check_int("hold_zr.dat", int'($signed(bus.dat_o)), 300);
        bus.set_hold_i = 1'b0; bus.zero_req_i = 1'b0;

        // Bypass jumps immediately, then track resumes from the bypassed value
        drive(-2000, 10);    bus.set_bypass_i = 1'b1;
        step("bypass", 1'b1);
        bus.set_bypass_i = 1'b0;
        drive(0, 10);        step("byp_track", 1'b1);

        // Counter saturation: step=1 with an alternating full-scale target clips every cycle
        bus.clr_cnt_i = 1'b1; drive(8191, 1); step("cnt_clr", 1'b1);
        bus.clr_cnt_i = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            drive((i % 2) ? 8191 : -8192, 1);
            step("cnt_fill", 1'b0);
        end
        check_int("cnt.fffe", int'(bus.lim_cnt_o), 65534);
        for (int i = 1; i <= 3; i++) begin
            drive((i % 2) ? 8191 : -8192, 1);
            step($sformatf("cnt_sat%0d", i), 1'b1);
        end
        check_int("cnt.ffff", int'(bus.lim_cnt_o), 65535);
        drive(-8192, 1); bus.clr_cnt_i = 1'b1;
        step("cnt_clr_lim", 1'b1);
        bus.clr_cnt_i = 1'b0;
        check_int("cnt.cleared", int'(bus.lim_cnt_o), 0);

        // Asynchronous reset mid-ramp
        drive(500, 0);       step("ar_set", 1'b1);
        drive(500, 10);      bus.zero_req_i = 1'b1;
        step("ar_ramp", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("areset.dat_o",      int'(bus.dat_o),      0);
        check_int("areset.limiting_o", int'(bus.limiting_o), 0);
        check_int("areset.parked_o",   int'(bus.parked_o),   0);
        check_int("areset.lim_cnt_o",  int'(bus.lim_cnt_o),  0);
        model_reset();
        rst_n = 1'b1;
        bus.zero_req_i = 1'b0;
        drive(500, 10);
        step("ar_post1", 1'b1);
        step("ar_post2", 1'b1);
        check_int("ar_post.dat", int'($signed(bus.dat_o)), 20);

        check_int("sb.empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
